// File: rtl/raster_pkg.sv
// Shared types and helpers for the line rasterizer: FSM states, default
// screen geometry and the constant-width framebuffer address helper.
package raster_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} raster_state_t;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // y*width + x as a shift-add over the set bits of width; with a constant
    // width this folds down to a few adders.
    function automatic logic [31:0] screen_addr(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input int          width);
        logic [31:0] acc;
        acc = x;
        for (int i = 0; i < 31; i++)
            if (width[i]) acc = acc + (y << i);
        return acc;
    endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham datapath: converts latched centre-origin endpoints to screen space
// on load, then walks one point per advance and flags on-screen points.
module bresenham_stepper
    import raster_pkg::*;
#(
    parameter int COORD_W  = 13,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      adv_i,
    input  logic signed [COORD_W-1:0] sx_i,
    input  logic signed [COORD_W-1:0] sy_i,
    input  logic signed [COORD_W-1:0] ex_i,
    input  logic signed [COORD_W-1:0] ey_i,
    output logic        [COORD_W-1:0] px_o,
    output logic        [COORD_W-1:0] py_o,
    output logic                      on_o,
    output logic                      last_o
);
    localparam int PW = COORD_W + 2;
    localparam int EW = COORD_W + 4;
    typedef logic signed [PW-1:0] pos_t;
    typedef logic signed [EW-1:0] err_t;

    pos_t sx0, sy0, ex0, ey0, ddx, ddy, adx, ady;
    logic signed [1:0] stx, sty;
    pos_t cx_q, cx_d, cy_q, cy_d, dx_q, dx_d, dy_q, dy_d, steps_q, steps_d;
    logic signed [1:0] stepx_q, stepx_d, stepy_q, stepy_d;
    err_t err_q, err_d, e2;

    // Screen space: x shifted right by half a width, y flipped so rows grow down.
    always_comb begin
        sx0 = pos_t'(sx_i) + pos_t'(SCREEN_W / 2);
        ex0 = pos_t'(ex_i) + pos_t'(SCREEN_W / 2);
        sy0 = pos_t'(SCREEN_H / 2) - pos_t'(sy_i);
        ey0 = pos_t'(SCREEN_H / 2) - pos_t'(ey_i);
        ddx = ex0 - sx0;
        ddy = ey0 - sy0;
        adx = ddx[PW-1] ? -ddx : ddx;
        ady = ddy[PW-1] ? -ddy : ddy;
        stx = ddx[PW-1] ? 2'b11 : ((ddx != '0) ? 2'b01 : 2'b00);
        sty = ddy[PW-1] ? 2'b11 : ((ddy != '0) ? 2'b01 : 2'b00);
    end

    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        stepx_d = stepx_q;
        stepy_d = stepy_q;
        err_d   = err_q;
        steps_d = steps_q;
        e2      = err_q <<< 1;
        if (load_i) begin
            cx_d    = sx0;
            cy_d    = sy0;
            dx_d    = adx;
            dy_d    = ady;
            stepx_d = stx;
            stepy_d = sty;
            err_d   = err_t'(adx) - err_t'(ady);
            steps_d = (adx > ady) ? adx : ady;
        end else if (adv_i && (steps_q != '0)) begin
            // Both tests use the pre-step error; the updates accumulate.
            if (e2 > -err_t'(dy_q)) begin
                err_d = err_d - err_t'(dy_q);
                cx_d  = cx_q + pos_t'(stepx_q);
            end
            if (e2 < err_t'(dx_q)) begin
                err_d = err_d + err_t'(dx_q);
                cy_d  = cy_q + pos_t'(stepy_q);
            end
            steps_d = steps_q - pos_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            stepx_q <= '0;
            stepy_q <= '0;
            err_q   <= '0;
            steps_q <= '0;
        end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            stepx_q <= stepx_d;
            stepy_q <= stepy_d;
            err_q   <= err_d;
            steps_q <= steps_d;
        end
    end

    assign on_o   = !cx_q[PW-1] && (cx_q < pos_t'(SCREEN_W)) &&
                    !cy_q[PW-1] && (cy_q < pos_t'(SCREEN_H));
    assign last_o = (steps_q == '0);
    assign px_o   = cx_q[COORD_W-1:0];
    assign py_o   = cy_q[COORD_W-1:0];

endmodule

// File: rtl/line_raster_stream.sv
// Streaming line rasterizer: accepts one line per handshake, steps it with
// Bresenham and emits clipped on-screen pixels with framebuffer addresses.
module line_raster_stream
    import raster_pkg::*;
#(
    parameter int COORD_W  = 13,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COLOR_W  = 4,
    parameter int ADDR_W   = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      line_valid,
    output logic                      line_ready,
    input  logic signed [COORD_W-1:0] start_x,
    input  logic signed [COORD_W-1:0] start_y,
    input  logic signed [COORD_W-1:0] end_x,
    input  logic signed [COORD_W-1:0] end_y,
    input  logic        [COLOR_W-1:0] line_color,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic        [COORD_W-1:0] pix_x,
    output logic        [COORD_W-1:0] pix_y,
    output logic        [ADDR_W-1:0]  pix_addr,
    output logic        [COLOR_W-1:0] pix_color,
    output logic                      line_done,
    output logic                      busy
);
    raster_state_t state_q, state_d;
    logic signed [COORD_W-1:0] sx_q, sy_q, ex_q, ey_q;
    logic [COLOR_W-1:0] color_q;
    logic on, last, adv, accept;

    assign accept = (state_q == IDLE) && line_valid;
    // Off-screen points retire without waiting for the consumer.
    assign adv    = !on || pix_ready;

    always_comb begin
        state_d    = state_q;
        line_ready = 1'b0;
        line_done  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                line_ready = 1'b1;
                busy       = 1'b0;
                if (line_valid) state_d = SETUP;
            end
            SETUP: state_d = DRAW;
            DRAW: begin
                if (adv && last) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sx_q    <= start_x;
                sy_q    <= start_y;
                ex_q    <= end_x;
                ey_q    <= end_y;
                color_q <= line_color;
            end
        end
    end

    bresenham_stepper #(
        .COORD_W (COORD_W),
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_stepper (
        .clk   (clk),
        .rst   (rst),
        .load_i(state_q == SETUP),
        .adv_i ((state_q == DRAW) && adv),
        .sx_i  (sx_q),
        .sy_i  (sy_q),
        .ex_i  (ex_q),
        .ey_i  (ey_q),
        .px_o  (pix_x),
        .py_o  (pix_y),
        .on_o  (on),
        .last_o(last)
    );

    assign pix_valid = (state_q == DRAW) && on;
    assign pix_color = color_q;
    assign pix_addr  = ADDR_W'(screen_addr(32'(pix_x), 32'(pix_y), SCREEN_W));

endmodule
